// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op and state encodings,
// iteration count and the RISC-V special-case result helper.
package div_pkg;

  localparam int unsigned DIV_ITERS = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_S_IDLE = 2'b00,
    DIV_S_CALC = 2'b01,
    DIV_S_FIX  = 2'b10,
    DIV_S_DONE = 2'b11
  } div_state_e;

  // DIV and REM are the signed ops (op[0] clear).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (op[1] set).
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  // Architecturally defined results for divide-by-zero and signed overflow.
  // When b_zero is clear the caller guarantees the signed-overflow case.
  function automatic logic [31:0] special_value(input logic [1:0]  op,
                                                input logic [31:0] a_raw,
                                                input logic        b_zero);
    logic [31:0] val;
    if (b_zero) begin
      val = op_is_rem(op) ? a_raw : 32'hFFFF_FFFF;
    end else begin
      val = op_is_rem(op) ? 32'h0000_0000 : 32'h8000_0000;
    end
    return val;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, subtract the
// divisor from the widened partial remainder and keep it when non-negative.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         ge;

  assign shifted = {rem_i, quo_i[W-1]};
  assign ge      = (shifted >= {1'b0, divisor_i});
  // When ge holds the true difference is below 2^W, so the low W bits suffice.
  assign diff    = shifted[W-1:0] - divisor_i;

  // Select restored or subtracted remainder and shift in the quotient bit.
  always_comb begin
    rem_o = ge ? diff : shifted[W-1:0];
    quo_o = {quo_i[W-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU). Restoring algorithm on
// absolute values, 32 CALC cycles, a FIX cycle for sign and special cases,
// then a single-cycle done pulse. All outputs are registered.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow go straight from IDLE to DONE; results are identical either way.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, a_raw_q;
  logic [1:0]      op_q;
  logic            a_neg_q, b_neg_q, b_zero_q, ovf_q;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            sgn_in, a_neg_in, b_neg_in, b_zero_in, ovf_in, fast_in;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [XLEN-1:0] fix_result;

  // Request decode: flush always wins over a simultaneous start.
  assign accept    = (state_q == DIV_S_IDLE) && start_i && !flush_i;
  assign sgn_in    = op_is_signed(op_i);
  assign a_neg_in  = sgn_in & a_i[XLEN-1];
  assign b_neg_in  = sgn_in & b_i[XLEN-1];
  assign a_abs     = a_neg_in ? -a_i : a_i;
  assign b_abs     = b_neg_in ? -b_i : b_i;
  assign b_zero_in = (b_i == '0);
  assign ovf_in    = sgn_in && (a_i == MinNeg) && (b_i == '1);

`ifdef DIV_FAST_SPECIAL_EN
  assign fast_in = b_zero_in | ovf_in;
`else
  assign fast_in = 1'b0;
`endif

  div_step #(
    .W (XLEN)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  // Sign correction on the magnitudes, with the special cases overriding.
  always_comb begin
    logic [XLEN-1:0] q_fix, r_fix;
    logic            q_neg;
    q_neg = (a_neg_q ^ b_neg_q) & ~b_zero_q;
    q_fix = q_neg ? -quo_q : quo_q;
    r_fix = a_neg_q ? -rem_q : rem_q;
    if (b_zero_q || ovf_q) begin
      fix_result = special_value(op_q, a_raw_q, b_zero_q);
    end else begin
      fix_result = op_is_rem(op_q) ? r_fix : q_fix;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DIV_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_S_IDLE: begin
        if (accept) begin
          state_d = fast_in ? DIV_S_DONE : DIV_S_CALC;
        end
      end
      DIV_S_CALC: begin
        if (flush_i) begin
          state_d = DIV_S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = DIV_S_FIX;
        end
      end
      DIV_S_FIX:  state_d = flush_i ? DIV_S_IDLE : DIV_S_DONE;
      DIV_S_DONE: state_d = DIV_S_IDLE;
      default:    state_d = DIV_S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      DIV_S_IDLE: begin
        if (accept) begin
          busy_d = !fast_in;
`ifdef DIV_FAST_SPECIAL_EN
          if (fast_in) begin
            done_d   = 1'b1;
            result_d = special_value(op_i, a_i, b_zero_in);
          end
`endif
        end
      end
      DIV_S_CALC: begin
        if (flush_i) begin
          busy_d = 1'b0;
        end
      end
      DIV_S_FIX: begin
        // Stall releases in the same cycle done is seen.
        busy_d = 1'b0;
        if (!flush_i) begin
          done_d   = 1'b1;
          result_d = fix_result;
        end
      end
      DIV_S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Operand capture on accept and one restoring step per CALC cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      op_q     <= DIV_OP_DIV;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      cnt_q    <= CntW'(DIV_ITERS - 1);
      rem_q    <= '0;
      quo_q    <= a_abs;
      dvs_q    <= b_abs;
      a_raw_q  <= a_i;
      op_q     <= op_i;
      a_neg_q  <= a_neg_in;
      b_neg_q  <= b_neg_in;
      b_zero_q <= b_zero_in;
      ovf_q    <= ovf_in;
    end else if (state_q == DIV_S_CALC) begin
      cnt_q <= cnt_q - 1'b1;
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit. Cycle numbering: the cycle in
// which start is sampled high is cycle 0; done is expected in cycle 34
// (or cycle 1 for special cases when DIV_FAST_SPECIAL_EN is defined).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 34;
`endif

  always #5 clk = ~clk;

  div_unit #(
    .XLEN (32)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  // Drive a start for one cycle; returns #1 after the accepting edge (cycle 1).
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called in cycle 1; returns at the negedge of the done cycle (or 61 on timeout).
  task automatic wait_done(output int cyc, output logic busy1);
    logic got;
    got = 1'b0;
    cyc = 1;
    busy1 = 1'b0;
    while (cyc <= 60 && !got) begin
      @(negedge clk);
      if (cyc == 1) busy1 = busy;
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    int   cyc;
    logic busy1;
    start_op(o, x, y);
    wait_done(cyc, busy1);
    checks++;
    if (cyc !== lat) begin
      errors++;
      $display("FAIL %s_latency: got cycle %0d, expected %0d", name, cyc, lat);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h, expected %h", name, result, exp);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: got %b, expected 0", name, busy);
    end
    checks++;
    if (busy1 !== (lat > 1)) begin
      errors++;
      $display("FAIL %s_busy_cycle1: got %b, expected %b", name, busy1, (lat > 1));
    end
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s_idle: got %0d cycles with done/busy, expected 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h, expected 0/0/0",
               busy, done, result);
    end
  endtask

  task automatic test_basic();
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
    run_op("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
  endtask

  task automatic test_special();
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);
    run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, SpecLat);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);
    run_op("remu_x_0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, SpecLat);
    run_op("rem_neg_0", 2'b10, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFEC, SpecLat);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SpecLat);
    // Same operands unsigned are an ordinary division.
    run_op("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
  endtask

  task automatic test_start_while_busy();
    int   cyc;
    logic busy1;
    start_op(2'b01, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, busy1);
    cyc = cyc + 4;
    checks++;
    if (cyc !== 34 || result !== 32'd14) begin
      errors++;
      $display("FAIL busy_start_ignored: got cycle %0d result %h, expected 34 and %h",
               cyc, result, 32'd14);
    end
    watch_idle("busy_start_no_second_done", 45);
  endtask

  task automatic test_flush(input logic [31:0] prev);
    int   cyc;
    int   seen;
    logic busy1;
    seen = 0;
    start_op(2'b01, 32'd100, 32'd7);
    repeat (9) begin
      @(negedge clk);
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done) seen++;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (seen != 0 || busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
      errors++;
      $display("FAIL flush_abort: got done_seen=%0d busy=%b done=%b result=%h, expected 0/0/0/%h",
               seen, busy, done, result, prev);
    end
    // Restart in cycle 11.
    start = 1'b1; op = 2'b00; a = 32'hFFFF_FFEC; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, busy1);
    checks++;
    if (cyc + 11 !== 45 || result !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL flush_restart: got cycle %0d result %h, expected 45 and %h",
               cyc + 11, result, 32'hFFFF_FFFA);
    end
  endtask

  task automatic test_flush_with_start();
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    watch_idle("flush_wins_over_start", 40);
    checks++;
    if (result !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL flush_start_result: got %h, expected %h", result, 32'hFFFF_FFFA);
    end
  endtask

  task automatic test_rst_mid();
    start_op(2'b01, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b result=%h, expected 0/0/0",
               busy, done, result);
    end
    watch_idle("rst_mid_no_done", 40);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    run_op("back_to_back_divu", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    test_start_while_busy();
    test_flush(32'd14);
    test_flush_with_start();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
